// File: rtl/iob_eth_tx_frame_loader.sv
// rtl/iob_eth_tx_frame_loader.sv - payload buffer and launch handshake for the Ethernet MII transmitter
module iob_eth_tx_frame_loader #(
    parameter int ADDR_W    = 11,
    parameter int MAX_BYTES = 1500,
    parameter int MIN_BYTES = 46
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_valid,
    input  logic [7:0]        i_wr_data,
    input  logic              i_wr_last,
    output logic              o_wr_ready,
    input  logic [47:0]       i_cfg_dest_mac,
    input  logic [47:0]       i_cfg_src_mac,
    input  logic [ADDR_W-1:0] i_tx_addr,
    output logic [7:0]        o_tx_data,
    output logic [ADDR_W-1:0] o_tx_nbytes,
    output logic [47:0]       o_dest_mac_addr,
    output logic [47:0]       o_src_mac_addr,
    output logic              o_tx_send,
    input  logic              i_tx_done,
    output logic              o_busy,
    output logic              o_overflow,
    output logic [15:0]       o_frame_count
);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_PAD  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam logic [ADDR_W-1:0] MAX_C = ADDR_W'(MAX_BYTES);
    localparam logic [ADDR_W-1:0] MIN_C = ADDR_W'(MIN_BYTES);
    localparam logic [ADDR_W-1:0] ONE_C = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_tx_nbytes;
    logic [47:0]       r_dest_mac;
    logic [47:0]       r_src_mac;
    logic              r_overflow;
    logic [15:0]       r_frame_count;
    logic              r_busy;
    logic [7:0]        r_mem [2**ADDR_W];

    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] w_next_count;
    logic              w_we;
    logic [7:0]        w_wdata;
    logic              w_set_ovf;
    logic              w_clr_ovf;
    logic              w_done;

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_we         = 1'b0;
        w_wdata      = 8'h00;
        w_set_ovf    = 1'b0;
        w_clr_ovf    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (i_wr_valid) begin
                    if (r_count < MAX_C) begin
                        w_we         = 1'b1;
                        w_wdata      = i_wr_data;
                        w_next_count = r_count + ONE_C;
                        w_clr_ovf    = (r_count == '0);
                    end else begin
                        w_set_ovf = 1'b1;
                    end
                    // A dropped last byte still closes the frame at MAX_BYTES.
                    if (i_wr_last)
                        w_next_state = (w_next_count >= MIN_C) ? ST_SEND : ST_PAD;
                end
            end
            ST_PAD: begin
                w_we         = 1'b1;
                w_next_count = r_count + ONE_C;
                if (w_next_count == MIN_C)
                    w_next_state = ST_SEND;
            end
            ST_SEND: w_next_state = ST_WAIT;
            default: begin
                if (i_tx_done) begin
                    w_done       = 1'b1;
                    w_next_count = '0;
                    w_next_state = ST_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_LOAD;
            r_count       <= '0;
            r_tx_nbytes   <= '0;
            r_dest_mac    <= '0;
            r_src_mac     <= '0;
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (r_state == ST_SEND) begin
                r_tx_nbytes <= r_count;
                r_dest_mac  <= i_cfg_dest_mac;
                r_src_mac   <= i_cfg_src_mac;
            end
            if (w_set_ovf)
                r_overflow <= 1'b1;
            else if (w_clr_ovf)
                r_overflow <= 1'b0;
            if (w_done)
                r_frame_count <= r_frame_count + 16'd1;
            r_busy <= (w_next_state != ST_LOAD);
        end
    end

    // Buffer is not reset; the gate keeps the host from writing while reset is held.
    always_ff @(posedge i_clk) begin
        if (w_we && !i_rst)
            r_mem[r_count] <= w_wdata;
    end

    assign o_wr_ready      = (r_state == ST_LOAD);
    assign o_tx_send       = (r_state == ST_SEND);
    assign o_tx_data       = r_mem[i_tx_addr];
    assign o_tx_nbytes     = r_tx_nbytes;
    assign o_dest_mac_addr = r_dest_mac;
    assign o_src_mac_addr  = r_src_mac;
    assign o_busy          = r_busy;
    assign o_overflow      = r_overflow;
    assign o_frame_count   = r_frame_count;

endmodule

// File: doc/iob_eth_tx_frame_loader.md
# iob_eth_tx_frame_loader

Upstream companion of the Ethernet MII transmitter. Accepts the host's payload as a byte stream, stores it in an internal byte buffer, zero-pads short frames to the Ethernet minimum, and latches the MAC addresses. It then hands the frame to the transmitter using a send/done handshake. The transmitter reads payload bytes back through a combinational address/data port.

## Interface
Parameters:
- `ADDR_W`, 11: buffer address width; buffer depth is 2^ADDR_W bytes.
- `MAX_BYTES`, 1500: maximum payload bytes stored per frame; must be < 2^ADDR_W.
- `MIN_BYTES`, 46: minimum payload length after padding; must be ≥ 1 and ≤ MAX_BYTES.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: host byte valid.
- `wr_data` in 8: host payload byte.
- `wr_last` in 1: qualifies the final byte of a frame.
- `wr_ready` out 1: block accepts a byte this cycle.
- `cfg_dest_mac` in 48: destination MAC, sampled at frame launch.
- `cfg_src_mac` in 48: source MAC, sampled at frame launch.
- `tx_addr` in ADDR_W: transmitter read address.
- `tx_data` out 8: buffer byte at `tx_addr`, combinational.
- `tx_nbytes` out ADDR_W: payload length of the launched frame.
- `dest_mac_addr` out 48: latched destination MAC.
- `src_mac_addr` out 48: latched source MAC.
- `tx_send` out 1: one-cycle launch pulse.
- `tx_done` in 1: one-cycle pulse from the transmitter when the frame is finished.
- `busy` out 1: high in every state except LOAD.
- `overflow` out 1: sticky flag; a byte was dropped in the current or last frame.
- `frame_count` out 16: number of completed frames.

## Operation
States: LOAD, PAD, SEND, WAIT.
- **LOAD**
  - `wr_ready`=1.
  - When `wr_valid`, the block does the following:
    - writes `mem[count]`=`wr_data` and increments `count`, provided `count`<MAX_BYTES;
    - otherwise drops the byte and sets `overflow`.
  - When `wr_valid & wr_last`, the frame closes.
    - New count ≥ MIN_BYTES → SEND.
    - New count < MIN_BYTES → PAD.
  - The first accepted byte of a frame clears `overflow`, unless that byte is itself dropped.
- **PAD**
  - Each cycle writes `mem[count]`=0 and increments `count`.
  - Leaves for SEND in the cycle `count` becomes MIN_BYTES.
  - `wr_ready`=0.
- **SEND**
  - Lasts one cycle, with `tx_send`=1.
  - Latches `tx_nbytes`=`count`, `dest_mac_addr`=`cfg_dest_mac`, `src_mac_addr`=`cfg_src_mac`.
  - Goes to WAIT.
- **WAIT**
  - Holds all outputs.
  - On `tx_done`: `frame_count`+1 (modulo 2^16), `count`=0, then LOAD.
- Buffer writes happen only in LOAD and PAD, so `tx_data` is stable for any fixed `tx_addr` during SEND and WAIT.
- Reads at `tx_addr` ≥ `tx_nbytes` return unspecified data.
- Counter width is ADDR_W. `count` never exceeds MAX_BYTES, so it never wraps.

## Timing
- Reset values:
  - state=LOAD, `count`=0;
  - `tx_send`=0, `tx_nbytes`=0, `dest_mac_addr`=0, `src_mac_addr`=0;
  - `overflow`=0, `frame_count`=0, `busy`=0;
  - `wr_ready`=1, combinational from state; no write is accepted while `rst` is high.
  - Buffer contents are not reset.
- Reset mid-frame in any state aborts the frame immediately: `tx_send` drops and the partial frame is discarded.
- Latency from `wr_last` accepted at cycle T:
  - no padding needed: `tx_send` at T+1;
  - otherwise `tx_send` at T+1+(MIN_BYTES−n), where n is the byte count including the last byte.
- `tx_done` outside WAIT is ignored.
- `tx_done` in the SEND cycle is ignored; the transmitter must not assert `tx_done` before the cycle after `tx_send`.
- `wr_valid` during PAD, SEND or WAIT is ignored, and the host holds the byte.
- After `tx_done` at cycle T, `wr_ready`=1 at T+1.
- A `wr_valid` byte presented in the same cycle as `tx_done` is not accepted.
- A dropped byte carrying `wr_last` still closes the frame, with `count`=MAX_BYTES.
- `busy` is registered and high from the cycle after leaving LOAD until the cycle after `tx_done`.

## Test plan
- **Minimum-size frame:** 46 bytes 0x00..0x2D, last on the 46th.
  - Next cycle `tx_send`=1 with no PAD cycles.
  - `tx_nbytes`=46.
  - `tx_data` at addr 0x2D = 0x2D.
- **Short frame:** 3 bytes 0xA1, 0xA2, 0xA3 with last.
  - PAD runs 43 cycles, then `tx_send`.
  - `tx_nbytes`=46.
  - Addr 2 = 0xA3; addr 3..45 = 0x00.
- **Overflow:** 1502 bytes with last on the 1502nd.
  - `overflow`=1, `tx_nbytes`=1500, addr 1499 = byte 1499.
  - The next frame's first byte clears `overflow`.
- **Handshake and MACs:**
  - `cfg_dest_mac` is changed one cycle after `tx_send`; `dest_mac_addr` must hold its SEND-cycle value.
  - `tx_done` pulse → `frame_count`=1 and `wr_ready`=1 the next cycle.
  - A spurious `tx_done` in LOAD leaves `frame_count` unchanged.
- **Back-to-back writes:** `wr_valid` held high continuously across `tx_done`.
  - The byte presented in the `tx_done` cycle is not accepted.
  - The second frame starts at addr 0.
- **Reset mid-operation:** `rst` asserted mid-PAD and again in WAIT.
  - All outputs return to their reset values asynchronously.
  - A new 46-byte frame then launches normally.
